// File: rtl/fn_scan_pkg.sv
// Shared widths and state encoding for the truth-table scanner.
// The scanner and its settle timer both import this package.
package fn_scan_pkg;

  localparam int N_IN  = 4;
  localparam int TT_W  = 2 ** N_IN;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds each vector for SETTLE extra cycles.
// The zero flag tells the scanner that the current vector may be sampled.
module settle_timer #(
  parameter int SETTLE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  import fn_scan_pkg::*;

  logic [CNT_W-1:0] cnt_r;

  // Counter register: load has priority over decrement and it saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= CNT_W'(SETTLE);
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps a,b,c,d through all 16 vectors and captures s_in into a truth table.
// At completion it reports the count of ones and compares the table against expected.
module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_in,
  input  logic [15:0] expected,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_data,
  output logic [4:0]  ones,
  output logic        mismatch,
  output logic        table_valid
);
  import fn_scan_pkg::*;

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  scan_state_e     state_r;
  logic [N_IN-1:0] vec_r;
  logic [TT_W-1:0] table_r;
  logic [4:0]      ones_r;
  logic            busy_r;
  logic            done_r;
  logic            mismatch_r;
  logic            valid_r;

  logic            zero_s;
  logic            load_s;
  logic            en_s;
  logic            last_s;
  logic [TT_W-1:0] next_table_s;

  // Timer control and the table as it will look once the current vector is stored.
  always_comb begin
    last_s       = (vec_r == VEC_LAST);
    en_s         = (state_r == SCAN) && !abort;
    next_table_s = table_r;
    next_table_s[vec_r] = s_in;
    if (state_r == IDLE) begin
      load_s = start;
    end else begin
      load_s = en_s && zero_s && !last_s;
    end
  end

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .load(load_s),
    .en  (en_s),
    .zero(zero_s)
  );

  // Scan FSM: abort beats sampling; mismatch is judged on the final table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      vec_r      <= {N_IN{1'b0}};
      table_r    <= {TT_W{1'b0}};
      ones_r     <= 5'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mismatch_r <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= SCAN;
            vec_r      <= {N_IN{1'b0}};
            table_r    <= {TT_W{1'b0}};
            ones_r     <= 5'd0;
            busy_r     <= 1'b1;
            mismatch_r <= 1'b0;
            valid_r    <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            vec_r   <= {N_IN{1'b0}};
          end else if (zero_s) begin
            table_r <= next_table_s;
            ones_r  <= ones_r + {4'b0000, s_in};
            if (last_s) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              valid_r    <= 1'b1;
              vec_r      <= {N_IN{1'b0}};
              mismatch_r <= (next_table_s != expected);
            end else begin
              vec_r <= vec_r + {{(N_IN-1){1'b0}}, 1'b1};
            end
          end else begin
            state_r <= SCAN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          vec_r   <= {N_IN{1'b0}};
        end
      endcase
    end
  end

  assign a           = vec_r[N_IN-1];
  assign b           = vec_r[N_IN-2];
  assign c           = vec_r[N_IN-3];
  assign d           = vec_r[N_IN-4];
  assign busy        = busy_r;
  assign done        = done_r;
  assign table_data  = table_r;
  assign ones        = ones_r;
  assign mismatch    = mismatch_r;
  assign table_valid = valid_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: two scanners (SETTLE=0 and SETTLE=2) sweep a function given as a
// 16-bit lookup; results are compared against a reference computed from that lookup.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [2];
  logic        abort_v [2];
  logic [15:0] exp_v   [2];
  logic [15:0] fn_v    [2];
  logic        s_w     [2];
  logic        a_o     [2];
  logic        b_o     [2];
  logic        c_o     [2];
  logic        d_o     [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [15:0] tbl_o   [2];
  logic [4:0]  ones_o  [2];
  logic        mm_o    [2];
  logic        tv_o    [2];

  int n_vec = 0;
  int n_bad = 0;

  // Function under test: s = fn[{a,b,c,d}]; 16'h1894 is the fabcd of the functional scan.
  assign s_w[0] = fn_v[0][{a_o[0], b_o[0], c_o[0], d_o[0]}];
  assign s_w[1] = fn_v[1][{a_o[1], b_o[1], c_o[1], d_o[1]}];

  truth_table_scanner #(.N_IN(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .s_in(s_w[0]),
    .expected(exp_v[0]), .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .d(d_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .table_data(tbl_o[0]), .ones(ones_o[0]),
    .mismatch(mm_o[0]), .table_valid(tv_o[0])
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .s_in(s_w[1]),
    .expected(exp_v[1]), .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .d(d_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .table_data(tbl_o[1]), .ones(ones_o[1]),
    .mismatch(mm_o[1]), .table_valid(tv_o[1])
  );

  typedef struct {
    int          k;
    logic [15:0] fn;
    logic [15:0] ex;
    logic [15:0] want_tbl;
    logic [4:0]  want_ones;
    logic        want_mm;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [3:0] vec_of(input int k);
    return {a_o[k], b_o[k], c_o[k], d_o[k]};
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Full scan from an idle (or done-cycle) negedge; ends on the negedge where done is high.
  task automatic run_scan(input int k, input logic [15:0] fn, input logic [15:0] ex,
                          input logic [15:0] want_tbl, input logic [4:0] want_ones,
                          input logic want_mm, input int restart_at);
    int hold;
    hold = settle_of(k) + 1;
    fn_v[k]    = fn;
    exp_v[k]   = ex;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check("valid_cleared_on_start", tv_o[k], 1'b0);
    for (int j = 0; j < 16 * hold; j++) begin
      start_v[k] = (j == restart_at);
      check("vec_sequence", vec_of(k), j / hold);
      check("busy_during_scan", busy_o[k], 1'b1);
      check("no_early_done", done_o[k], 1'b0);
      @(negedge clk);
    end
    start_v[k] = 1'b0;
    check("done_pulse", done_o[k], 1'b1);
    check("busy_after_done", busy_o[k], 1'b0);
    check("vec_back_to_0", vec_of(k), 4'h0);
    check("table", tbl_o[k], want_tbl);
    check("ones", ones_o[k], want_ones);
    check("mismatch", mm_o[k], want_mm);
    check("table_valid", tv_o[k], 1'b1);
  endtask

  task automatic done_drops(input int k);
    @(negedge clk);
    check("done_one_cycle", done_o[k], 1'b0);
    check("valid_held", tv_o[k], 1'b1);
  endtask

  // Start a scan, abort it jab cycles after acceptance and check the retained partial state.
  task automatic abort_scan(input int k, input logic [15:0] fn, input int jab);
    int hold;
    logic [15:0] part;
    hold = settle_of(k) + 1;
    fn_v[k]    = fn;
    exp_v[k]   = fn;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int j = 0; j < jab; j++) @(negedge clk);
    abort_v[k] = 1'b1;
    @(negedge clk);
    abort_v[k] = 1'b0;
    part = fn & ((16'h0001 << (jab / hold)) - 16'h0001);
    check("abort_busy", busy_o[k], 1'b0);
    check("abort_vec", vec_of(k), 4'h0);
    check("abort_valid", tv_o[k], 1'b0);
    check("abort_partial_table", tbl_o[k], part);
    check("abort_partial_ones", ones_o[k], $countones(part));
    for (int j = 0; j < 20 * hold; j++) begin
      check("abort_no_done", done_o[k], 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input int k);
    check("rst_busy", busy_o[k], 1'b0);
    check("rst_done", done_o[k], 1'b0);
    check("rst_vec", vec_of(k), 4'h0);
    check("rst_table", tbl_o[k], 16'h0000);
    check("rst_ones", ones_o[k], 5'd0);
    check("rst_mismatch", mm_o[k], 1'b0);
    check("rst_valid", tv_o[k], 1'b0);
  endtask

  initial begin
    logic [15:0] fn;
    logic [15:0] ex;
    int          k;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      exp_v[i]   = 16'h0000;
      fn_v[i]    = 16'h0000;
    end
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;
    @(negedge clk);

    vt[0] = '{0, 16'h1894, 16'h1894, 16'h1894, 5'd5,  1'b0};
    vt[1] = '{0, 16'h1894, 16'h1895, 16'h1894, 5'd5,  1'b1};
    vt[2] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0};
    vt[3] = '{1, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b0};
    vt[4] = '{0, 16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 1'b1};
    vt[5] = '{1, 16'h1894, 16'h1894, 16'h1894, 5'd5,  1'b0};
    for (int i = 0; i < 6; i++) begin
      run_scan(vt[i].k, vt[i].fn, vt[i].ex, vt[i].want_tbl, vt[i].want_ones, vt[i].want_mm, -1);
      done_drops(vt[i].k);
    end

    // Random functions against the reference: table equals the function, ones is its popcount.
    for (int i = 0; i < 10; i++) begin
      k  = $urandom_range(0, 1);
      fn = 16'($urandom);
      ex = ($urandom_range(0, 1) == 0) ? fn : (fn ^ (16'h0001 << $urandom_range(0, 15)));
      run_scan(k, fn, ex, fn, 5'($countones(fn)), (fn != ex), -1);
      done_drops(k);
    end

    abort_scan(0, 16'h1894, 5);
    run_scan(0, 16'h1894, 16'h1894, 16'h1894, 5'd5, 1'b0, -1);
    done_drops(0);
    abort_scan(1, 16'hA5C3, 16);
    run_scan(1, 16'hA5C3, 16'hA5C3, 16'hA5C3, 5'd8, 1'b0, -1);
    done_drops(1);

    // Reset while dut0 drives vector 9.
    fn_v[0]    = 16'h1894;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("vec9_before_rst", vec_of(0), 4'h9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(0);
    check_reset_state(1);
    repeat (20) begin
      check("rst_no_done", done_o[0], 1'b0);
      @(negedge clk);
    end

    // A start mid-scan is ignored, then a start in the done cycle chains a new scan.
    run_scan(0, 16'h1894, 16'h1894, 16'h1894, 5'd5, 1'b0, 7);
    run_scan(0, 16'h3C0F, 16'h3C0F, 16'h3C0F, 5'd8, 1'b0, -1);
    done_drops(0);
    run_scan(1, 16'h1894, 16'h1895, 16'h1894, 5'd5, 1'b1, 20);
    run_scan(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0, -1);
    done_drops(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
